// File: rtl/alarm_snooze_if.sv
// Alarm/snooze control bus: time-of-day, alarm setting and user controls in,
// buzzer drive and event status out.
//   master: drives alarmon, snooze, tsec/tmin/thrs, amin/ahrs; reads buzz, state, snooze_left
//   slave : the alarm_snooze block
interface alarm_snooze_if;
  logic       alarmon;
  logic       snooze;
  logic [6:0] tsec;
  logic [6:0] tmin;
  logic [6:0] thrs;
  logic [6:0] amin;
  logic [6:0] ahrs;
  logic       buzz;
  logic [1:0] state;
  logic [2:0] snooze_left;

  modport master (
    output alarmon, snooze, tsec, tmin, thrs, amin, ahrs,
    input  buzz, state, snooze_left
  );

  modport slave (
    input  alarmon, snooze, tsec, tmin, thrs, amin, ahrs,
    output buzz, state, snooze_left
  );
endinterface

// File: rtl/alarm_snooze.sv
// Alarm clock ring/snooze controller, one clock cycle per second.
// Ports:
//   clk  - 1 Hz clock
//   rst  - synchronous active-high reset
//   bus  - alarm_snooze_if.slave: alarmon, snooze, current time (tsec/tmin/thrs),
//          alarm time (amin/ahrs) in; buzz, state (00 idle, 01 ringing,
//          10 snoozed) and snooze_left out.
module alarm_snooze #(
  parameter int unsigned SNOOZE_SEC = 540,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic          clk,
  input  logic          rst,
  alarm_snooze_if.slave bus
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned LEFT_W = 3;
  localparam int unsigned TIME_W = 7;

  localparam logic [CNT_W-1:0]  RING_LAST   = CNT_W'(RING_SEC - 1);
  localparam logic [CNT_W-1:0]  SNOOZE_LOAD = CNT_W'(SNOOZE_SEC - 1);
  localparam logic [LEFT_W-1:0] LEFT_INIT   = LEFT_W'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RING = 2'b01,
    ST_SNZ  = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    ring_q, ring_d;
  logic [CNT_W-1:0]    tmr_q, tmr_d;
  logic [LEFT_W-1:0]   left_q, left_d;
  logic                buzz_q;
  logic                match_c;

  // True only on the first second of the alarm minute.
  assign match_c = bus.alarmon
                && (bus.thrs == bus.ahrs)
                && (bus.tmin == bus.amin)
                && (bus.tsec == TIME_W'(0));

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    tmr_d   = tmr_q;
    left_d  = left_q;

    if (!bus.alarmon) begin
      // Disabling the alarm overrides every other event.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (match_c) begin
            state_d = ST_RING;
            ring_d  = '0;
          end
        end
        ST_RING: begin
          // Snooze beats timeout when presses remain; otherwise it is ignored.
          if (bus.snooze && (left_q != '0)) begin
            state_d = ST_SNZ;
            left_d  = left_q - LEFT_W'(1);
            tmr_d   = SNOOZE_LOAD;
          end else if (ring_q == RING_LAST) begin
            state_d = ST_IDLE;
          end else begin
            ring_d = ring_q + CNT_W'(1);
          end
        end
        ST_SNZ: begin
          if (tmr_q == '0) begin
            state_d = ST_RING;
            ring_d  = '0;
          end else begin
            tmr_d = tmr_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Every return to idle arms a full set of snoozes for the next event.
    if (state_d == ST_IDLE) begin
      left_d = LEFT_INIT;
    end
  end

  // State and counter registers; buzz is registered from the next state so it
  // is a clean flop output aligned with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ring_q  <= '0;
      tmr_q   <= '0;
      left_q  <= LEFT_INIT;
      buzz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      tmr_q   <= tmr_d;
      left_q  <= left_d;
      buzz_q  <= (state_d == ST_RING);
    end
  end

  assign bus.state       = state_q;
  assign bus.buzz        = buzz_q;
  assign bus.snooze_left = left_q;

endmodule

// File: doc/alarm_snooze.md
ALARM_SNOOZE -- requirements
Module: alarm_snooze

Interface
REQ-001 Parameter SNOOZE_SEC, default 540, is the snooze interval in clock cycles (seconds); the legal range SHALL be 1..1023.
REQ-002 Parameter RING_SEC, default 60, is the maximum continuous ring time in cycles; the legal range SHALL be 1..1023.
REQ-003 Parameter MAX_SNOOZE, default 3, is the number of snoozes allowed per alarm event; the legal range SHALL be 0..7.
REQ-004 clk  input  1  SHALL be the single clock, one cycle per second (the Pulse domain).
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 alarmon  input  1  SHALL be the alarm master enable switch.
REQ-007 snooze  input  1  SHALL be the snooze button, sampled each cycle (level, not edge).
REQ-008 tsec, tmin, thrs  input  7 each  SHALL carry the current time in binary: sec 0-59, min 0-59, hrs 0-23.
REQ-009 amin, ahrs  input  7 each  SHALL carry the alarm setting in binary.
REQ-010 buzz  output  1  SHALL be the audible alarm drive.
REQ-011 state  output  2  SHALL be the FSM state: 00 IDLE, 01 RINGING, 10 SNOOZED (11 unused).
REQ-012 snooze_left  output  3  SHALL report the snoozes remaining in the current event.

Function
REQ-013 Match SHALL be defined as alarmon && thrs==ahrs && tmin==amin && tsec==0, so it is true for one cycle per minute at most.
REQ-014 IDLE -> RINGING: match is sampled at edge n; state==RINGING from edge n.
REQ-015 buzz SHALL equal (state==RINGING), decoded from registered state with no further delay; the output SHALL be glitch-free.
REQ-016 A ring counter SHALL clear on every entry to RINGING and increment every cycle in RINGING.
REQ-017 RINGING -> IDLE when the ring counter == RING_SEC-1 (timeout); buzz SHALL therefore last exactly RING_SEC cycles.
REQ-018 RINGING -> SNOOZED when snooze==1 and snooze_left>0.
  - On this transition, snooze_left SHALL decrement and the snooze timer SHALL load SNOOZE_SEC-1.
REQ-019 snooze==1 in RINGING with snooze_left==0 SHALL be ignored; ringing continues until timeout.
REQ-020 SNOOZED SHALL decrement the snooze timer each cycle; SNOOZED -> RINGING on the cycle the timer reads 0.
  - The gap from the last buzz cycle to the first re-ring buzz cycle SHALL therefore be SNOOZE_SEC cycles.
REQ-021 The snooze input SHALL be ignored in SNOOZED.
REQ-022 alarmon==0 in any state SHALL force IDLE at the next edge; this takes priority over timeout, snooze, and timer expiry.
REQ-023 Match while in RINGING or SNOOZED SHALL be ignored (no restart of counters).
REQ-024 Snooze and timeout in the same RINGING cycle: snooze SHALL win when snooze_left>0.
REQ-025 snooze_left SHALL reload to MAX_SNOOZE on every entry to IDLE.
REQ-026 Changing amin/ahrs mid-event SHALL NOT affect the event in progress.
REQ-027 Counters SHALL be 10 bits and SHALL never wrap; they hold when not in their owning state.

Reset
REQ-028 On rst==1 at an edge: state=IDLE, buzz=0, snooze_left=MAX_SNOOZE, ring counter=0, snooze timer=0.
REQ-029 rst SHALL take priority over all inputs, including a simultaneous match.
REQ-030 rst asserted mid-RINGING or mid-SNOOZED SHALL abort the event.
  - No ringing SHALL resume after reset until the next match.

Verification
REQ-031 Basic ring and timeout: alarm 07:30, alarmon=1, time reaches 07:30:00 -> buzz high for exactly 60 cycles starting at that edge, then state=00.
REQ-032 Snooze cycle: at ring cycle 10, snooze=1 for 1 cycle -> state=10, snooze_left=2, buzz low for 540 cycles, then buzz high again with a fresh 60-cycle window.
REQ-033 Snooze exhaustion: press snooze 3 times, once in each ring window -> the 4th press is ignored, snooze_left=0, buzz times out after 60 cycles, then state=00 and snooze_left=3.
REQ-034 Alarm disabled: alarmon dropped in RINGING (and separately in SNOOZED with timer=100) -> next edge state=00, buzz=0; alarmon=0 at 07:30:00 -> no ring.
REQ-035 Reset and collision: rst=1 coincident with the match cycle -> state=00, buzz=0; rst mid-snooze -> no re-ring at timer expiry.
REQ-036 Parameter edge: RING_SEC=1, SNOOZE_SEC=1, MAX_SNOOZE=0 -> single-cycle buzz on match, snooze ignored.
